fifo_drain: RTL and testbench
=============================

# fifo_drain

Read-side controller for the byte FIFO buffer. It pops a requested number of bytes from the FIFO's read port, compensates for the FIFO's one-cycle read latency with a 2-entry skid buffer, and presents the bytes as a valid/ready stream with a last-byte marker. It sits between the FIFO output and any downstream consumer such as a UART TX or packet framer, and also forwards FIFO error conditions.

## Interface
Parameters:
- DATA_WIDTH, 8, FIFO and stream data width
- LEN_WIDTH, 8, width of the burst length request

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  burst request pulse, sampled only in IDLE
- len  in  LEN_WIDTH  number of bytes to drain, sampled with start
- fifo_rden  out  1  FIFO read strobe
- fifo_data  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rden
- fifo_oready  in  1  FIFO non-empty
- fifo_err  in  1  FIFO error flag
- tdata  out  DATA_WIDTH  stream data
- tvalid  out  1  stream data valid
- tready  in  1  downstream accept
- tlast  out  1  marks the final byte of the burst
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse when a burst completes normally
- err  out  1  sticky abort flag, cleared by the next accepted start

## Operation
- States: IDLE, RUN, FLUSH, ABORT.
- IDLE:
  - start=1 with len≠0: latch len into remaining, clear issued, clear err, go to RUN.
  - start=1 with len=0: pulse done next cycle and stay in IDLE. No reads are issued.
- RUN:
  - fifo_rden = fifo_oready && (issued < len) && (occ + inflight − pop) < 2.
  - occ is the skid occupancy (0..2). inflight is 1 if fifo_rden was high last cycle. pop is tvalid && tready.
  - When issued reaches len, go to FLUSH.
- FLUSH: no reads. When the last byte is popped (remaining 1 → 0), pulse done and go to IDLE.
- Data capture: when inflight=1, fifo_data is written into the skid tail. The capture never overflows; the credit rule guarantees it.
- Stream outputs:
  - tdata and tvalid come from the skid head.
  - tlast = tvalid && (remaining == 1).
  - remaining decrements on each pop.
- Error handling:
  - fifo_err=1 while in RUN or FLUSH: go to ABORT, set err, deassert fifo_rden immediately, discard the skid contents and any in-flight byte.
  - ABORT lasts one cycle, then goes to IDLE. done is not pulsed.
- start is ignored while busy=1.
- Counters are LEN_WIDTH bits wide and never wrap; issued saturates at len.
- Stream protocol: once tvalid is high, tdata and tlast hold until accepted.

## Timing
- Reset values: fifo_rden=0, tvalid=0, tlast=0, tdata=0, busy=0, done=0, err=0, state=IDLE, occ=0, inflight=0.
- Burst latency:
  - start is sampled at edge E0, and RUN is active after E0.
  - The first fifo_rden is combinational in the cycle after E0, provided fifo_oready=1.
  - tvalid goes high 2 edges after the first fifo_rden.
- Sustained throughput is 1 byte/cycle while tready=1 and fifo_oready=1.
- Backpressure:
  - With tready=0, at most 2 bytes are read ahead and fifo_rden drops.
  - Reads resume in the same cycle a pop frees a slot.
- An empty FIFO mid-burst stalls fifo_rden. No timeout.
- done is high exactly one cycle, in the cycle after the final pop.
- busy falls in the same cycle done rises.
- If fifo_err and the final pop occur in the same cycle, the error wins: err=1 and no done.
- Asynchronous reset mid-burst clears all state immediately. The FIFO is not rewound.

## Structure
- Shared package holds:
  - the state enumeration (IDLE, RUN, FLUSH, ABORT)
  - the SKID_DEPTH=2 constant
  - the READ_LATENCY=1 constant
- One sub-module: skid_buffer_2. It is a 2-entry register FIFO with push, pop, occ, head data and flush inputs and outputs. The controller FSM and counters stay in fifo_drain.

## Test plan
- Reset with fifo_oready=1 and start=0: all outputs stay 0 and fifo_rden is never asserted.
- FIFO preloaded 0x11..0x14, start with len=4, tready=1: bytes 0x11,0x12,0x13,0x14 on 4 consecutive cycles, tlast only on 0x14, done one cycle later, exactly 4 fifo_rden pulses.
- len=6 with tready toggling 1,0,0,1,…: no byte lost or duplicated, occ never exceeds 2, at most 2 reads ahead while tready=0.
- len=3 with fifo_oready low for 5 cycles after the first byte: fifo_rden stays 0 during the gap, the stream resumes in order, and done pulses once.
- len=0: done pulses the cycle after start, busy stays 0, and no fifo_rden.
- len=8 with fifo_err asserted after the 3rd pop: the next cycle has fifo_rden=0 and tvalid=0, err=1 sticks, no done. A following start with len=1 clears err and completes normally.

Source files
------------

// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO read-side drain controller.
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    ABORT
  } state_t;

  localparam int SKID_DEPTH   = 2;
  localparam int READ_LATENCY = 1;

endpackage

// File: rtl/fifo_drain_if.sv
// FIFO read port plus outgoing byte stream, bundled for the drain controller.
interface fifo_drain_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  fifo_rden;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_oready;
  logic                  fifo_err;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output fifo_rden, tdata, tvalid, tlast,
    input  fifo_data, fifo_oready, fifo_err, tready
  );

  modport slave (
    input  fifo_rden, tdata, tvalid, tlast,
    output fifo_data, fifo_oready, fifo_err, tready
  );

endinterface

// File: rtl/fifo_drain_skid_buffer_2.sv
// Two-entry register FIFO that absorbs read data arriving after the FIFO's read latency.
module skid_buffer_2
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  localparam int OCC_W     = $clog2(SKID_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  input  logic                  flush,
  output logic [OCC_W-1:0]      occ,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic                  pop_ok;

  assign pop_ok = pop && (occ != '0);
  assign dout   = head;

  // Head only moves on a pop, so the presented byte holds while it waits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      occ <= '0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (occ == '0) head <= din;
          else           tail <= din;
          occ <= occ + OCC_W'(1);
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - OCC_W'(1);
        end
        2'b11: begin
          if (occ == OCC_W'(1)) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_drain.sv
// Drains a requested number of bytes from the byte FIFO into a valid/ready stream
// with a last marker, aborting cleanly on a FIFO error.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  fifo_drain_if.master         bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int OCC_W = $clog2(SKID_DEPTH + 1);
  localparam int PW    = OCC_W + 1;

  state_t                  state, state_nx;
  logic [LEN_WIDTH-1:0]    len_q, issued, remaining;
  logic [READ_LATENCY-1:0] rd_pipe;
  logic [OCC_W-1:0]        occ;
  logic [DATA_WIDTH-1:0]   head;
  logic [PW-1:0]           pending;
  logic inflight, pop, rden, flush, load, done_nx, err_nx, credit_ok;

  assign inflight = rd_pipe[READ_LATENCY-1];
  assign pop      = bus.tvalid && bus.tready;

  // A read may only issue if its byte is guaranteed a skid slot when it lands.
  assign pending   = {1'b0, occ} + PW'(inflight);
  assign credit_ok = pending < (PW'(SKID_DEPTH) + PW'(pop));

  assign bus.fifo_rden = rden;
  assign bus.tvalid    = (occ != '0);
  assign bus.tdata     = head;
  assign bus.tlast     = bus.tvalid && (remaining == LEN_WIDTH'(1));
  assign busy          = (state != IDLE);

  skid_buffer_2 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .din   (bus.fifo_data),
    .pop   (pop),
    .flush (flush),
    .occ   (occ),
    .dout  (head)
  );

  always_comb begin
    state_nx = state;
    rden     = 1'b0;
    flush    = 1'b0;
    load     = 1'b0;
    done_nx  = 1'b0;
    err_nx   = err;
    case (state)
      IDLE: begin
        if (start) begin
          err_nx = 1'b0;
          if (len != '0) begin
            load     = 1'b1;
            state_nx = RUN;
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.fifo_err) begin
          state_nx = ABORT;
          err_nx   = 1'b1;
          flush    = 1'b1;
        end else begin
          rden = bus.fifo_oready && (issued < len_q) && credit_ok;
          if (rden && (issued == len_q - LEN_WIDTH'(1))) state_nx = FLUSH;
        end
      end
      FLUSH: begin
        if (bus.fifo_err) begin
          state_nx = ABORT;
          err_nx   = 1'b1;
          flush    = 1'b1;
        end else if (pop && (remaining == LEN_WIDTH'(1))) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      ABORT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      done      <= 1'b0;
      err       <= 1'b0;
      rd_pipe   <= '0;
      len_q     <= '0;
      issued    <= '0;
      remaining <= '0;
    end else begin
      state   <= state_nx;
      done    <= done_nx;
      err     <= err_nx;
      rd_pipe <= flush ? '0 : READ_LATENCY'({rd_pipe, rden});
      if (load) begin
        len_q     <= len;
        remaining <= len;
        issued    <= '0;
      end else begin
        if (rden) issued <= issued + LEN_WIDTH'(1);
        if (pop && (remaining != '0)) remaining <= remaining - LEN_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_drain.sv
// Scoreboard bench for fifo_drain: a behavioural FIFO feeds the DUT and every
// streamed byte is matched against the bytes loaded into that FIFO.
module tb_fifo_drain;

  localparam int DW = 8;
  localparam int LW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          busy, done, err;

  fifo_drain_if #(.DATA_WIDTH(DW)) bus ();

  fifo_drain #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .len   (len),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial forever #5 clk = ~clk;

  int assert_count = 0;
  int fail_count   = 0;
  int cyc          = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Behavioural FIFO with one-cycle read latency; it is never rewound.
  logic [DW-1:0] mem [0:255];
  logic [7:0]    wr_ptr = '0;
  logic [7:0]    rd_ptr = '0;
  logic          gate = 1'b0;
  logic          tready_drv = 1'b1;
  logic          err_drv = 1'b0;

  assign bus.fifo_oready = (rd_ptr != wr_ptr) && !gate;
  assign bus.tready      = tready_drv;
  assign bus.fifo_err    = err_drv;

  always @(posedge clk) begin
    if (bus.fifo_rden) begin
      bus.fifo_data <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 8'd1;
    end
  end

  exp_t exp_q[$];

  task automatic loadFifo(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = base + DW'(i);
      wr_ptr      = wr_ptr + 8'd1;
      exp_q.push_back('{data: base + DW'(i), last: (i == n - 1)});
    end
  endtask

  // Stimulus modes selected by the main sequence, applied by the driver process.
  bit toggle_mode = 0, gap_mode = 0, err_mode = 0;
  bit gap_started = 0, err_fired = 0;
  int tcnt = 0, gap_left = 0;

  // Burst statistics, cleared by the monitor when a start is accepted.
  int rden_count = 0, pop_count = 0, done_count = 0, rden_in_gap = 0, max_ahead = 0;
  int start_cyc = -1, first_rden = -1, first_valid = -1, first_pop = -1, last_pop = -1;
  int done_cyc = -1;
  logic busy_at_done = 1'b1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_mode) begin
        tready_drv = (tcnt % 3 == 0);
        tcnt++;
      end else begin
        tready_drv = 1'b1;
        tcnt       = 0;
      end
      if (!gap_mode) begin
        gap_started = 0;
        gap_left    = 0;
        gate        = 1'b0;
      end else if (gap_left > 0) begin
        gap_left--;
        if (gap_left == 0) gate = 1'b0;
      end else if (!gap_started && busy && rden_count >= 1) begin
        gate        = 1'b1;
        gap_left    = 5;
        gap_started = 1;
      end
      if (!err_mode) begin
        err_fired = 0;
        err_drv   = 1'b0;
      end else if (!err_fired && busy && pop_count == 3) begin
        err_drv   = 1'b1;
        err_fired = 1;
      end else begin
        err_drv = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted byte and gathers burst timing.
  initial begin
    bit            hold_pending = 0;
    logic [DW-1:0] held_data;
    logic          held_last;
    exp_t          e;
    int            ahead;
    forever begin
      @(negedge clk);
      if (!reset) begin
        hold_pending = 0;
      end else begin
        if (start && !busy) begin
          rden_count = 0; pop_count = 0; done_count = 0; rden_in_gap = 0; max_ahead = 0;
          first_rden = -1; first_valid = -1; first_pop = -1; last_pop = -1; done_cyc = -1;
          start_cyc = cyc;
        end
        if (bus.fifo_rden) begin
          rden_count++;
          if (first_rden < 0) first_rden = cyc;
          if (gate) rden_in_gap++;
        end
        if (hold_pending) begin
          checkOutput("hold_tvalid", 32'(bus.tvalid), 32'd1);
          checkOutput("hold_tdata", 32'(bus.tdata), 32'(held_data));
          checkOutput("hold_tlast", 32'(bus.tlast), 32'(held_last));
        end
        if (bus.tvalid && first_valid < 0) first_valid = cyc;
        if (bus.tvalid && bus.tready) begin
          if (exp_q.size() == 0) begin
            checkOutput("sb_pop_expected", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            checkOutput("tdata", 32'(bus.tdata), 32'(e.data));
            checkOutput("tlast", 32'(bus.tlast), 32'(e.last));
          end
          pop_count++;
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
        end
        ahead = rden_count - pop_count;
        if (ahead > max_ahead) max_ahead = ahead;
        hold_pending = bus.tvalid && !bus.tready;
        held_data    = bus.tdata;
        held_last    = bus.tlast;
        if (done) begin
          done_count++;
          done_cyc     = cyc;
          busy_at_done = busy;
        end
      end
    end
  end

  task automatic applyStimulus(input int n, input int budget);
    @(posedge clk);
    #1;
    start = 1'b1;
    len   = LW'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < budget && done_count == 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, assertions %0d", assert_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with a non-empty FIFO and no start: nothing may move.
    loadFifo(4, 8'h11);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rden_count", 32'(rden_count), 32'd0);
    checkOutput("rst_tvalid", 32'(bus.tvalid), 32'd0);
    checkOutput("rst_tlast", 32'(bus.tlast), 32'd0);
    checkOutput("rst_tdata", 32'(bus.tdata), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);

    $display("[TB] burst len=4 full rate");
    applyStimulus(4, 40);
    checkOutput("b4_rden_count", 32'(rden_count), 32'd4);
    checkOutput("b4_first_rden", 32'(first_rden), 32'(start_cyc + 1));
    checkOutput("b4_first_valid", 32'(first_valid), 32'(first_rden + 2));
    checkOutput("b4_pop_span", 32'(last_pop - first_pop), 32'd3);
    checkOutput("b4_done_cycle", 32'(done_cyc), 32'(last_pop + 1));
    checkOutput("b4_busy_at_done", 32'(busy_at_done), 32'd0);
    checkOutput("b4_done_count", 32'(done_count), 32'd1);
    checkOutput("b4_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] burst len=6 with tready toggling");
    loadFifo(6, 8'h20);
    toggle_mode = 1;
    applyStimulus(6, 100);
    toggle_mode = 0;
    checkOutput("b6_rden_count", 32'(rden_count), 32'd6);
    checkOutput("b6_max_ahead", 32'(max_ahead), 32'd2);
    checkOutput("b6_done_count", 32'(done_count), 32'd1);
    checkOutput("b6_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] burst len=3 with FIFO empty gap");
    loadFifo(3, 8'h30);
    gap_mode = 1;
    applyStimulus(3, 100);
    gap_mode = 0;
    checkOutput("b3_rden_count", 32'(rden_count), 32'd3);
    checkOutput("b3_rden_in_gap", 32'(rden_in_gap), 32'd0);
    checkOutput("b3_pop_span", 32'(last_pop - first_pop), 32'd7);
    checkOutput("b3_done_count", 32'(done_count), 32'd1);
    checkOutput("b3_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] zero-length request");
    loadFifo(8, 8'h40);
    @(posedge clk);
    #1;
    start = 1'b1;
    len   = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("z_done_pulse", 32'(done), 32'd1);
    checkOutput("z_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("z_done_drop", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("z_rden_count", 32'(rden_count), 32'd0);

    $display("[TB] burst len=8 aborted by FIFO error");
    err_mode = 1;
    @(posedge clk);
    #1;
    start = 1'b1;
    len   = LW'(8);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 60 && !err_fired; k++) @(negedge clk);
    checkOutput("e_err_injected", 32'(err_fired), 32'd1);
    checkOutput("e_rden_on_err", 32'(bus.fifo_rden), 32'd0);
    @(negedge clk);
    checkOutput("e_abort_rden", 32'(bus.fifo_rden), 32'd0);
    checkOutput("e_abort_tvalid", 32'(bus.tvalid), 32'd0);
    checkOutput("e_abort_err", 32'(err), 32'd1);
    checkOutput("e_abort_busy", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    checkOutput("e_err_sticky", 32'(err), 32'd1);
    checkOutput("e_idle", 32'(busy), 32'd0);
    checkOutput("e_no_done", 32'(done_count), 32'd0);
    checkOutput("e_pops", 32'(pop_count), 32'd4);
    err_mode = 0;
    exp_q.delete();

    $display("[TB] burst len=1 after abort");
    exp_q.push_back('{data: mem[rd_ptr], last: 1'b1});
    applyStimulus(1, 40);
    checkOutput("r1_err_cleared", 32'(err), 32'd0);
    checkOutput("r1_done_count", 32'(done_count), 32'd1);
    checkOutput("r1_rden_count", 32'(rden_count), 32'd1);
    checkOutput("r1_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
